// File: rtl/boot_pkg.sv
// Shared constants for the boot image sender: FSM state encoding and 8N1 frame layout.
// The verify path is compiled in with the BOOT_VERIFY_EN macro.
package boot_pkg;

    localparam int unsigned DefaultClkPerBit = 868;

    localparam int unsigned DataBits = 8;
    localparam logic        StartBit = 1'b0;
    localparam logic        StopBit  = 1'b1;
    localparam bit          HiFirst  = 1'b1;

    typedef logic [3:0] state_t;

    localparam state_t StIdle     = 4'd0;
    localparam state_t StPrefetch = 4'd1;
    localparam state_t StSendHi   = 4'd2;
    localparam state_t StSendLo   = 4'd3;
    localparam state_t StScan     = 4'd4;
    localparam state_t StRxHi     = 4'd5;
    localparam state_t StRxLo     = 4'd6;
    localparam state_t StCmp      = 4'd7;
    localparam state_t StFinish   = 4'd8;

endpackage

// File: rtl/boot_image_sender_if.sv
// Image ROM bus between the sender (master) and a synchronous 1-cycle-latency ROM (slave).
interface boot_image_sender_if #(
    parameter int unsigned ADR_W = 6
);
    logic [ADR_W-1:0] img_adr;
    logic [15:0]      img_data;

    modport master (output img_adr, input img_data);
    modport slave  (input img_adr, output img_data);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter; ready rises in the last stop-bit cycle so bytes go back-to-back.
module uart_byte_tx
    import boot_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DefaultClkPerBit
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ce_i,
    input  logic       valid_i,
    input  logic [7:0] byte_i,
    output logic       ready_o,
    output logic       tx_o
);
    localparam int unsigned     CntW    = $clog2(CLK_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_BIT - 1);
    localparam logic [3:0]      StopIdx = 4'(DataBits + 1);

    logic            active_q, active_d;
    logic [3:0]      bit_q, bit_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = cnt_q == CntLast;
    assign ready_o = !active_q || (bit_q == StopIdx && bit_end);
    assign tx_o    = tx_q;

    // bit_q: 0 = start, 1..8 = data LSB first, 9 = stop
    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (valid_i && ready_o) begin
            active_d = 1'b1;
            bit_d    = '0;
            cnt_d    = '0;
            shift_d  = byte_i;
            tx_d     = StartBit;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                if (bit_q == StopIdx) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    tx_d    = (bit_q == 4'(DataBits)) ? StopBit : shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            tx_q     <= StopBit;
        end else if (ce_i) begin
            active_q <= active_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end
endmodule

// File: rtl/boot_image_sender.sv
// Streams an N_WORDS x 16-bit image over UART; with BOOT_VERIFY_EN it also requests a memory
// scan and compares the returned dump against the image.
module boot_image_sender
    import boot_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = DefaultClkPerBit,
    parameter int unsigned N_WORDS     = 64,
    parameter int unsigned ADR_W       = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ce_i,
    input  logic                start_i,
    boot_image_sender_if.master img_bus,
    output logic                tx_o,
`ifdef BOOT_VERIFY_EN
    input  logic                rx_i,
    output logic                scan_req_o,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [ADR_W:0]      err_count_o
);
    state_t           state_q, state_d;
    logic [ADR_W-1:0] word_q, word_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [7:0]       second_q, second_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_word;
    logic [7:0]       first_byte, second_byte;
    logic             tx_valid, tx_ready;
    logic [7:0]       tx_byte;

    assign last_word   = word_q == ADR_W'(N_WORDS - 1);
    assign first_byte  = HiFirst ? img_bus.img_data[15:8] : img_bus.img_data[7:0];
    assign second_byte = HiFirst ? img_bus.img_data[7:0] : img_bus.img_data[15:8];

    assign img_bus.img_adr = adr_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

    uart_byte_tx #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_tx (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ce_i   (ce_i),
        .valid_i(tx_valid),
        .byte_i (tx_byte),
        .ready_o(tx_ready),
        .tx_o   (tx_o)
    );

    // Address is held at 0 in IDLE, so word 0 is already on img_data during PREFETCH.
    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = second_q;
        case (state_q)
            StPrefetch: begin
                tx_valid = 1'b1;
                tx_byte  = first_byte;
            end
            StSendHi: tx_valid = tx_ready;
            StSendLo: begin
                if (!last_word) begin
                    tx_valid = tx_ready;
                    tx_byte  = first_byte;
                end
            end
            default: ;
        endcase
    end

`ifdef BOOT_VERIFY_EN
    localparam int unsigned     CntW      = $clog2(CLK_PER_BIT);
    localparam logic [CntW-1:0] RxLast    = CntW'(CLK_PER_BIT - 1);
    localparam logic [CntW-1:0] RxSample  = CntW'(CLK_PER_BIT / 2);
    localparam logic [3:0]      RxStopIdx = 4'(DataBits + 1);
    localparam logic [ADR_W:0]  ErrMax    = (ADR_W + 1)'(N_WORDS);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic            rx_active_q, rx_active_d;
    logic [3:0]      rx_bit_q, rx_bit_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_en, rx_done;
    logic [7:0]      rx_first_q, rx_first_d, rx_second_q, rx_second_d;
    logic            frame_err_q, frame_err_d;
    logic            cmp_wait_q, cmp_wait_d;
    logic            err_q, err_d;
    logic [ADR_W:0]  err_cnt_q, err_cnt_d;
    logic [15:0]     rx_word;

    assign rx_en       = state_q == StScan || state_q == StRxHi || state_q == StRxLo ||
                         state_q == StCmp;
    assign rx_word     = HiFirst ? {rx_first_q, rx_second_q} : {rx_second_q, rx_first_q};
    assign scan_req_o  = state_q == StScan;
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;

    // rx_cnt_q counts cycles since the synchronized falling edge; sample mid-bit.
    always_comb begin
        rx_active_d = rx_active_q;
        rx_bit_d    = rx_bit_q;
        rx_cnt_d    = rx_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_done     = 1'b0;
        if (!rx_en) begin
            rx_active_d = 1'b0;
        end else if (!rx_active_q) begin
            if (rx_prev_q && !rx_sync_q) begin
                rx_active_d = 1'b1;
                rx_bit_d    = '0;
                rx_cnt_d    = CntW'(1);
            end
        end else begin
            if (rx_cnt_q == RxLast) begin
                rx_cnt_d = '0;
                rx_bit_d = rx_bit_q + 4'd1;
            end else begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
            if (rx_cnt_q == RxSample) begin
                if (rx_bit_q == RxStopIdx) begin
                    rx_done     = 1'b1;
                    rx_active_d = 1'b0;
                end else if (rx_bit_q != 4'd0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_active_q <= 1'b0;
            rx_bit_q    <= '0;
            rx_cnt_q    <= '0;
            rx_shift_q  <= '0;
            rx_first_q  <= '0;
            rx_second_q <= '0;
            frame_err_q <= 1'b0;
            cmp_wait_q  <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else if (ce_i) begin
            rx_meta_q   <= rx_i;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_active_q <= rx_active_d;
            rx_bit_q    <= rx_bit_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_first_q  <= rx_first_d;
            rx_second_q <= rx_second_d;
            frame_err_q <= frame_err_d;
            cmp_wait_q  <= cmp_wait_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end
`else
    assign err_o       = 1'b0;
    assign err_count_o = '0;
`endif

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        adr_d    = adr_q;
        second_d = second_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef BOOT_VERIFY_EN
        rx_first_d  = rx_first_q;
        rx_second_d = rx_second_q;
        frame_err_d = frame_err_q;
        cmp_wait_d  = cmp_wait_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                adr_d = '0;
                if (start_i) begin
                    state_d = StPrefetch;
                    busy_d  = 1'b1;
                    word_d  = '0;
`ifdef BOOT_VERIFY_EN
                    err_d     = 1'b0;
                    err_cnt_d = '0;
`endif
                end
            end
            StPrefetch: begin
                second_d = second_byte;
                state_d  = StSendHi;
            end
            StSendHi: begin
                if (tx_ready) begin
                    state_d = StSendLo;
                    if (!last_word) adr_d = word_q + 1'b1;
                end
            end
            StSendLo: begin
                if (tx_ready) begin
                    if (last_word) begin
`ifdef BOOT_VERIFY_EN
                        state_d = StScan;
                        word_d  = '0;
`else
                        state_d = StFinish;
`endif
                    end else begin
                        second_d = second_byte;
                        word_d   = word_q + 1'b1;
                        state_d  = StSendHi;
                    end
                end
            end
`ifdef BOOT_VERIFY_EN
            StScan: state_d = StRxHi;
            StRxHi: begin
                if (rx_done) begin
                    rx_first_d  = rx_shift_q;
                    frame_err_d = rx_sync_q != StopBit;
                    state_d     = StRxLo;
                end
            end
            StRxLo: begin
                if (rx_done) begin
                    rx_second_d = rx_shift_q;
                    frame_err_d = frame_err_q | (rx_sync_q != StopBit);
                    adr_d       = word_q;
                    cmp_wait_d  = 1'b1;
                    state_d     = StCmp;
                end
            end
            // First CMP cycle waits out the ROM read latency of the re-driven address.
            StCmp: begin
                cmp_wait_d = 1'b0;
                if (!cmp_wait_q) begin
                    if (frame_err_q || rx_word != img_bus.img_data) begin
                        err_d = 1'b1;
                        if (err_cnt_q != ErrMax) err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (last_word) begin
                        state_d = StFinish;
                    end else begin
                        word_d  = word_q + 1'b1;
                        state_d = StRxHi;
                    end
                end
            end
`endif
            StFinish: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                adr_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            word_q   <= '0;
            adr_q    <= '0;
            second_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (ce_i) begin
            state_q  <= state_d;
            word_q   <= word_d;
            adr_q    <= adr_d;
            second_q <= second_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_boot_image_sender.sv
// Directed bench for boot_image_sender with a 2-word image at 4 clocks per bit.
// Verify-path checks run when BOOT_VERIFY_EN is defined.
`timescale 1ns/1ps
module tb_boot_image_sender;
    localparam int unsigned Cpb    = 4;
    localparam int unsigned NWords = 2;
    localparam int unsigned AdrW   = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ce;
    logic            start;
    logic            tx, busy, done, err;
    logic [AdrW:0]   err_count;
`ifdef BOOT_VERIFY_EN
    logic            rx;
    logic            scan_req;
`endif

    boot_image_sender_if #(.ADR_W(AdrW)) img_bus ();

    logic [15:0] rom [NWords];
    logic        txv   [0:255];
    logic        busyv [0:255];
    logic        busy_c1;
    logic [AdrW-1:0] adr_c1;
    int          done_cyc, done_n;
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_bytes [4];

    always #5 clk = ~clk;

    always @(posedge clk) if (ce) img_bus.img_data <= rom[img_bus.img_adr];

    boot_image_sender #(
        .CLK_PER_BIT(Cpb),
        .N_WORDS    (NWords),
        .ADR_W      (AdrW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ce_i       (ce),
        .start_i    (start),
        .img_bus    (img_bus),
        .tx_o       (tx),
`ifdef BOOT_VERIFY_EN
        .rx_i       (rx),
        .scan_req_o (scan_req),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_count_o(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Cycle 0 is the cycle whose closing edge samples start; cycle c is read #1 after edge c-1.
    task automatic capture(input int ncyc, input bit hold);
        done_cyc = -1;
        done_n   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        busy_c1 = busy;
        adr_c1  = img_bus.img_adr;
        for (int c = 1; c < ncyc; c++) begin
            txv[c]   = tx;
            busyv[c] = busy;
            if (done === 1'b1) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_frames(input string tag, input int nbytes);
        logic [9:0] got;
        for (int b = 0; b < nbytes; b++) begin
            for (int j = 0; j < 10; j++) got[j] = txv[2 + b*10*Cpb + j*Cpb + Cpb/2];
            chk($sformatf("%s_frame%0d", tag, b), {22'd0, got}, {22'd0, 1'b1, exp_bytes[b], 1'b0});
        end
    endtask

`ifdef BOOT_VERIFY_EN
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx = frame[j];
            repeat (Cpb) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (Cpb) @(posedge clk);
        #1;
    endtask

    task automatic verify_run(input string tag, input logic [15:0] w1, input logic stop0,
                              input logic exp_err, input logic [AdrW:0] exp_cnt);
        int seen;
        int dn;
        seen = 0;
        dn   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            if (scan_req === 1'b1) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_scan_seen"}, seen, 1);
        @(posedge clk);
        #1;
        chk({tag, "_scan_pulse"}, {31'd0, scan_req}, 0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, stop0);
        send_byte(w1[15:8], 1'b1);
        send_byte(w1[7:0], 1'b1);
        for (int c = 0; c < 200 && dn == 0; c++) begin
            if (done === 1'b1) dn = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_done"}, dn, 1);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, "_err_count"}, {30'd0, err_count}, {30'd0, exp_cnt});
        chk({tag, "_busy"}, {31'd0, busy}, 0);
    endtask
`endif

    initial begin
        int dn;
        rom[0] = 16'h1234;
        rom[1] = 16'hABCD;
        exp_bytes[0] = 8'h12;
        exp_bytes[1] = 8'h34;
        exp_bytes[2] = 8'hAB;
        exp_bytes[3] = 8'hCD;
        ce    = 1'b1;
        start = 1'b0;
        rst_n = 1'b0;
`ifdef BOOT_VERIFY_EN
        rx = 1'b1;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_err_count", {30'd0, err_count}, 0);
        chk("rst_img_adr", {31'd0, img_bus.img_adr}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic transmit run
        capture(200, 1'b0);
        chk("run_busy_c1", {31'd0, busy_c1}, 1);
        chk("run_adr_c1", {31'd0, adr_c1}, 0);
        chk("run_tx_c1", {31'd0, txv[1]}, 1);
        chk("run_tx_c2", {31'd0, txv[2]}, 0);
        chk_frames("run", 4);
        chk("run_tx_last_stop", {31'd0, txv[161]}, 1);
        chk("run_tx_after", {31'd0, txv[162]}, 1);
`ifndef BOOT_VERIFY_EN
        chk("run_done_cycle", done_cyc, 163);
        chk("run_done_count", done_n, 1);
        chk("run_busy_at_done", {31'd0, busyv[163]}, 0);
        chk("run_busy_before_done", {31'd0, busyv[162]}, 1);

        // Start held high: one full run, next run only after done
        apply_reset();
        capture(170, 1'b1);
        chk_frames("hold", 4);
        chk("hold_done_count", done_n, 1);
        chk("hold_done_cycle", done_cyc, 163);
        chk("hold_busy_at_done", {31'd0, busyv[163]}, 0);
        chk("hold_busy_rerun", {31'd0, busyv[164]}, 1);
        start = 1'b0;
        dn = 0;
        for (int c = 0; c < 250 && dn == 0; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dn = 1;
        end
        chk("hold_second_done", dn, 1);
`endif

        // Reset in the middle of byte 0
        apply_reset();
        capture(20, 1'b0);
        chk("abort_tx_low_before", {31'd0, tx}, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", {31'd0, tx}, 1);
        chk("abort_busy", {31'd0, busy}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        capture(100, 1'b0);
        chk("restart_adr_c1", {31'd0, adr_c1}, 0);
        chk_frames("restart", 2);

`ifdef BOOT_VERIFY_EN
        apply_reset();
        verify_run("vok", 16'hABCD, 1'b1, 1'b0, 2'd0);
        apply_reset();
        verify_run("vbad", 16'hABCC, 1'b1, 1'b1, 2'd1);
        apply_reset();
        verify_run("vstop", 16'hABCD, 1'b0, 1'b1, 2'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
